// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit framer: parity codes, FSM encoding,
// per-frame configuration payload and the parity helper.
package uart_tx_pkg;

  localparam int unsigned MAX_WIDTH = 9;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } state_t;

  // Frame options captured together with a word
  typedef struct packed {
    logic       par_en;
    logic [1:0] par_type;
    logic       stop2;
  } frame_cfg_t;

  // Parity bit for a zero-extended data word (zero padding does not change XOR)
  function automatic logic par_calc(input logic [MAX_WIDTH-1:0] data,
                                    input logic [1:0]           par_type);
    logic p;
    p = 1'b0;
    case (par_type)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~^data;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_frame_gen_baud.sv
// Baud tick generator: counts 0..CLKS_PER_BIT-1 and flags the last count.
// Ports: clk, rst (async active-low), clear (sync restart), tick_c (last cycle of a bit).
// With CLKS_PER_BIT=1 the counter never leaves 0, so tick_c is always 1.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = (cnt_q == LAST);

  // Bit-period counter, wraps at every bit boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear || tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmit framer: start bit, WIDTH data bits LSB first, optional parity,
// one or two stop bits, with a one-entry holding buffer for back-to-back frames.
// Ports:
//   clk, rst (async active-low)
//   Data_valid, P_data[WIDTH], Par_en, Par_type[2], Stop2 : word request + options
//   Ready   : holding buffer empty
//   Busy    : frame on the line
//   TX_OUT  : serial line, idle high
//   Par_bit : parity of the frame currently or last on the line
module uart_tx_frame_gen
  import uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Data_valid,
  input  logic [WIDTH-1:0] P_data,
  input  logic             Par_en,
  input  logic [1:0]       Par_type,
  input  logic             Stop2,
  output logic             Ready,
  output logic             Busy,
  output logic             TX_OUT,
  output logic             Par_bit
);

  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             par_en_q, par_en_d;
  logic             stop2_q, stop2_d;
  logic             par_bit_q, par_bit_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  frame_cfg_t       hold_cfg_q, hold_cfg_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             tx_q, tx_d;

  frame_cfg_t       cfg_in;
  frame_cfg_t       load_cfg;
  logic [WIDTH-1:0] load_data;
  logic             load;
  logic             accept;
  logic             last_stop;
  logic             tick_c;

  assign cfg_in = '{par_en: Par_en, par_type: Par_type, stop2: Stop2};

  // Counter held at 0 while idle so every frame starts on a fresh bit period
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == ST_IDLE),
    .tick_c (tick_c)
  );

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    par_en_d    = par_en_q;
    stop2_d     = stop2_q;
    par_bit_d   = par_bit_q;
    hold_data_d = hold_data_q;
    hold_cfg_d  = hold_cfg_q;
    ready_d     = ready_q;
    load        = 1'b0;
    load_data   = P_data;
    load_cfg    = cfg_in;
    accept      = Data_valid && ready_q;
    last_stop   = tick_c && (((state_q == ST_STOP1) && !stop2_q) || (state_q == ST_STOP2));

    case (state_q)
      ST_IDLE:   if (accept) load = 1'b1;
      ST_START:  if (tick_c) state_d = ST_DATA;
      ST_DATA: begin
        if (tick_c) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? ST_PARITY : ST_STOP1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
      ST_PARITY: if (tick_c) state_d = ST_STOP1;
      ST_STOP1:  if (tick_c) state_d = stop2_q ? ST_STOP2 : ST_IDLE;
      ST_STOP2:  if (tick_c) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // End of frame chains straight into the next word, buffered one first
    if (last_stop) begin
      if (!ready_q) begin
        load      = 1'b1;
        load_data = hold_data_q;
        load_cfg  = hold_cfg_q;
        ready_d   = 1'b1;
      end else if (accept) begin
        load = 1'b1;
      end
    end else if (accept && (state_q != ST_IDLE)) begin
      hold_data_d = P_data;
      hold_cfg_d  = cfg_in;
      ready_d     = 1'b0;
    end

    if (load) begin
      state_d   = ST_START;
      shift_d   = load_data;
      bit_cnt_d = '0;
      par_en_d  = load_cfg.par_en;
      stop2_d   = load_cfg.stop2;
      par_bit_d = par_calc(MAX_WIDTH'(load_data), load_cfg.par_type);
    end

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_bit_d;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_en_q    <= 1'b0;
      stop2_q     <= 1'b0;
      par_bit_q   <= 1'b0;
      hold_data_q <= '0;
      hold_cfg_q  <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_en_q    <= par_en_d;
      stop2_q     <= stop2_d;
      par_bit_q   <= par_bit_d;
      hold_data_q <= hold_data_d;
      hold_cfg_q  <= hold_cfg_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      tx_q        <= tx_d;
    end
  end

  assign Ready   = ready_q;
  assign Busy    = busy_q;
  assign TX_OUT  = tx_q;
  assign Par_bit = par_bit_q;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Bench for uart_tx_frame_gen: four configurations share one stimulus stream,
// each compared cycle by cycle against a queue-of-line-bits reference model.
module tb_uart_tx_frame_gen;

  localparam int unsigned N_CFG = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] p_data = '0;
  logic       par_en = 1'b0;
  logic [1:0] par_type = '0;
  logic       stop2 = 1'b0;
  bit         chk_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // cfg0: W8 CPB1, cfg1: W8 CPB4, cfg2: W8 CPB2, cfg3: W5 CPB1
  for (genvar g = 0; g < N_CFG; g++) begin : g_cfg
    localparam int unsigned W   = (g == 3) ? 5 : 8;
    localparam int unsigned CPB = (g == 1) ? 4 : ((g == 2) ? 2 : 1);

    logic tx, busy, ready, par;

    uart_tx_frame_gen #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst        (rst),
      .Data_valid (dv),
      .P_data     (p_data[W-1:0]),
      .Par_en     (par_en),
      .Par_type   (par_type),
      .Stop2      (stop2),
      .Ready      (ready),
      .Busy       (busy),
      .TX_OUT     (tx),
      .Par_bit    (par)
    );

    // Model: line holds the per-cycle levels still to appear; line[0] is on the wire now
    bit         line[$];
    bit         pend_v = 1'b0;
    logic [7:0] pend_d;
    logic       pend_pe;
    logic [1:0] pend_pt;
    logic       pend_s2;
    bit         m_tx = 1'b1;
    bit         m_busy = 1'b0;
    bit         m_ready = 1'b1;
    bit         m_par = 1'b0;
    bit         acc;

    function automatic bit parity_of(input logic [7:0] d, input logic [1:0] pt);
      int ones = 0;
      for (int i = 0; i < int'(W); i++) ones += int'(d[i]);
      case (pt)
        2'b00:   return (ones % 2) == 1;
        2'b01:   return (ones % 2) == 0;
        2'b10:   return 1'b1;
        default: return 1'b0;
      endcase
    endfunction

    task automatic load_frame(input logic [7:0] d, input logic pe, input logic [1:0] pt,
                              input logic s2);
      bit bits[$];
      m_par = parity_of(d, pt);
      bits.push_back(1'b0);
      for (int i = 0; i < int'(W); i++) bits.push_back(d[i]);
      if (pe) bits.push_back(m_par);
      bits.push_back(1'b1);
      if (s2) bits.push_back(1'b1);
      line.delete();
      foreach (bits[k]) for (int c = 0; c < int'(CPB); c++) line.push_back(bits[k]);
    endtask

    initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        line.delete();
        pend_v  = 1'b0;
        m_ready = 1'b1;
        m_par   = 1'b0;
      end else begin
        acc = dv && m_ready;
        if (line.size() != 0) void'(line.pop_front());
        if (line.size() == 0) begin
          if (pend_v) begin
            load_frame(pend_d, pend_pe, pend_pt, pend_s2);
            pend_v  = 1'b0;
            m_ready = 1'b1;
          end else if (acc) begin
            load_frame(p_data, par_en, par_type, stop2);
          end
        end else if (acc) begin
          pend_d  = p_data;
          pend_pe = par_en;
          pend_pt = par_type;
          pend_s2 = stop2;
          pend_v  = 1'b1;
          m_ready = 1'b0;
        end
      end
      m_busy = (line.size() != 0);
      m_tx   = m_busy ? line[0] : 1'b1;
    end

    initial forever begin
      @(negedge clk);
      if (chk_en) begin
        check($sformatf("cfg%0d tx", g),    32'(tx),    32'(m_tx));
        check($sformatf("cfg%0d busy", g),  32'(busy),  32'(m_busy));
        check($sformatf("cfg%0d ready", g), 32'(ready), 32'(m_ready));
        check($sformatf("cfg%0d par", g),   32'(par),   32'(m_par));
      end
    end
  end

  function automatic bit all_idle();
    return !g_cfg[0].busy && g_cfg[0].ready && !g_cfg[1].busy && g_cfg[1].ready &&
           !g_cfg[2].busy && g_cfg[2].ready && !g_cfg[3].busy && g_cfg[3].ready;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!all_idle() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait_bound", 32'(n < 3000), 32'd1);
  endtask

  // Called at a negedge; the request is taken at the following rising edge
  task automatic send(input logic [7:0] d, input logic pe, input logic [1:0] pt, input logic s2);
    dv       = 1'b1;
    p_data   = d;
    par_en   = pe;
    par_type = pt;
    stop2    = s2;
    @(negedge clk);
    dv = 1'b0;
  endtask

  logic [7:0] par_tab_d  [5] = '{8'hAB, 8'hAB, 8'hAA, 8'hAA, 8'hAB};
  logic [1:0] par_tab_t  [5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
  logic       par_tab_e  [5] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0};

  initial begin
    logic [10:0] seq11;
    logic [7:0]  seq8;
    int          n;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst    = 1'b1;
    repeat (4) @(negedge clk);

    // 8'hAA even parity on the CPB=1 line
    send(8'hAA, 1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 11; i++) begin
      seq11[i] = g_cfg[0].tx;
      @(negedge clk);
    end
    check("aa_even_line", 32'(seq11), 32'(11'b10101010100));
    check("aa_even_par", 32'(g_cfg[0].par), 32'd0);

    // Parity flavours
    for (int i = 0; i < 5; i++) begin
      wait_idle();
      send(par_tab_d[i], 1'b1, par_tab_t[i], 1'b0);
      check($sformatf("par_kind%0d", i), 32'(g_cfg[0].par), 32'(par_tab_e[i]));
    end

    // CPB=4, no parity, two stop bits: 11 bits * 4 cycles
    wait_idle();
    send(8'h0F, 1'b0, 2'b00, 1'b1);
    n = 0;
    while (g_cfg[1].busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("cpb4_busy_len", 32'(n), 32'd44);

    // Back-to-back on CPB=2: two 20-cycle frames with no gap, first cycle already seen
    wait_idle();
    send(8'h55, 1'b0, 2'b00, 1'b0);
    send(8'hC3, 1'b0, 2'b00, 1'b0);
    check("b2b_ready_low", 32'(g_cfg[2].ready), 32'd0);
    n = 0;
    while (g_cfg[2].busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("b2b_busy_len", 32'(n), 32'd39);

    // WIDTH=5: reset during data bit 2, then a fresh frame
    wait_idle();
    send(8'h16, 1'b1, 2'b01, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_tx",    32'(g_cfg[3].tx),    32'd1);
    check("rst_busy",  32'(g_cfg[3].busy),  32'd0);
    check("rst_ready", 32'(g_cfg[3].ready), 32'd1);
    check("rst_par",   32'(g_cfg[3].par),   32'd0);
    check("rst_tx_cpb4", 32'(g_cfg[1].tx),  32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(8'h01, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      seq8[i] = g_cfg[3].tx;
      @(negedge clk);
    end
    check("w5_line", 32'(seq8), 32'(8'b10000010));
    check("w5_par", 32'(g_cfg[3].par), 32'd0);

    // Random traffic with occasional mid-frame resets
    for (int cyc = 0; cyc < 4000; cyc++) begin
      dv       = ($urandom_range(0, 2) == 0);
      p_data   = 8'($urandom);
      par_en   = 1'($urandom);
      par_type = 2'($urandom);
      stop2    = 1'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
      end
      @(negedge clk);
    end
    dv = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
